serial_adder_sub: RTL and testbench

Bit-serial, sequential counterpart of the team's combinational 4-bit adder/subtractor. It accepts an operand pair and an add/sub select through a start/busy/done handshake, and processes one bit per clock, LSB first. It then presents a registered sum/difference and carry-out whose values match the combinational unit bit-for-bit. It lets lab designs trade area for latency and serves as a sequential reference for the combinational unit.

---
 rtl/serial_adder_sub_pkg.sv | 19 +
 rtl/serial_adder_sub_fa.sv | 13 +
 rtl/serial_adder_sub.sv | 123 ++++++++++++
 tb/tb_serial_adder_sub.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_sub_pkg.sv
// Shared definitions for the bit-serial adder/subtractor: FSM encoding, operation codes
// and the counter-width helper.
package serial_adder_sub_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // The bit counter has to hold the value WIDTH itself, hence WIDTH+1.
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/serial_adder_sub_fa.sv
// Single-bit full adder used as the bit-serial datapath of serial_adder_sub.
module full_adder_1bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder_sub.sv
// Bit-serial adder/subtractor, LSB first, one bit per clock with a start/busy/done handshake.
// Define ADDSUB_OVF_EN to add the two's-complement overflow output V.
module serial_adder_sub
  import serial_adder_sub_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             sel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] S,
  output logic             Cout
`ifdef ADDSUB_OVF_EN
  ,
  output logic             V
`endif
);

  localparam int CNT_W = cnt_width(WIDTH);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               carry_q, carry_d;
  logic [WIDTH-1:0]   opA_q, opA_d;
  logic [WIDTH-1:0]   opB_q, opB_d;
  logic [WIDTH-1:0]   s_q, s_d;
  logic               cout_q, cout_d;
  logic               faSum, faCout;
`ifdef ADDSUB_OVF_EN
  logic               v_q, v_d;
`endif

  full_adder_1bit u_fa (
    .a    (opA_q[0]),
    .b    (opB_q[0]),
    .cin  (carry_q),
    .s    (faSum),
    .cout (faCout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      opA_q   <= '0;
      opB_q   <= '0;
      s_q     <= '0;
      cout_q  <= 1'b0;
`ifdef ADDSUB_OVF_EN
      v_q     <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      opA_q   <= opA_d;
      opB_q   <= opB_d;
      s_q     <= s_d;
      cout_q  <= cout_d;
`ifdef ADDSUB_OVF_EN
      v_q     <= v_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    opA_d   = opA_q;
    opB_d   = opB_q;
    s_d     = s_q;
    cout_d  = cout_q;
`ifdef ADDSUB_OVF_EN
    v_d     = v_q;
`endif
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          // Subtraction is A + ~B + 1: invert B now and seed the carry with 1.
          opA_d   = A;
          opB_d   = (sel == OP_ADD) ? B : ~B;
          carry_d = (sel == OP_SUB);
          cnt_d   = '0;
          state_d = ST_SHIFT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        s_d     = {faSum, s_q[WIDTH-1:1]};
        opA_d   = opA_q >> 1;
        opB_d   = opB_q >> 1;
        carry_d = faCout;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          cout_d  = faCout;
`ifdef ADDSUB_OVF_EN
          // On the MSB step carry_q is the carry into the MSB.
          v_d     = carry_q ^ faCout;
`endif
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy = (state_q == ST_SHIFT);
  assign done = (state_q == ST_DONE);
  assign S    = s_q;
  assign Cout = cout_q;
`ifdef ADDSUB_OVF_EN
  assign V    = v_q;
`endif

endmodule

// File: tb/tb_serial_adder_sub.sv
// Directed self-checking bench for serial_adder_sub (WIDTH=4); V is checked when ADDSUB_OVF_EN is defined.
module tb_serial_adder_sub;

  localparam int WIDTH = 4;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             sel;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] S;
  logic             Cout;
  logic             vObs;
`ifdef ADDSUB_OVF_EN
  logic             V;
  assign vObs = V;
`else
  assign vObs = 1'b0;
`endif

  int nCompared;
  int nMismatched;

  serial_adder_sub #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .A     (A),
    .B     (B),
    .sel   (sel),
    .busy  (busy),
    .done  (done),
    .S     (S),
    .Cout  (Cout)
`ifdef ADDSUB_OVF_EN
    ,
    .V     (V)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             op;
    logic [WIDTH-1:0] expS;
    logic             expC;
    logic             expV;
  } vec_t;

  // Issues one operation starting 1ns after a rising edge and waits (bounded) for done.
  task automatic doOp(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic op,
                      output int edges, output logic gotDone, output logic busyFirst);
    A = a; B = b; sel = op; start = 1'b1;
    edges = 0; gotDone = 1'b0; busyFirst = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      edges++;
      if (edges == 1) begin
        start = 1'b0;
        busyFirst = busy;
      end
      if (done) begin
        gotDone = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1; start = 1'b0; A = '0; B = '0; sel = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    nCompared++;
    if ({busy, done, S, Cout, vObs} !== '0) begin
      nMismatched++;
      $display("[TB] FAIL reset_values: busy=%b done=%b S=%b Cout=%b V=%b, required all 0", busy, done, S, Cout, vObs);
    end
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    nCompared++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL idle_after_reset: busy=%b done=%b, required 0 0", busy, done);
    end
  endtask

  task automatic test_add_sub();
    vec_t vecs[7];
    int edges;
    logic gotDone, busyFirst;
    vecs[0] = '{4'b0001, 4'b0010, 1'b0, 4'b0011, 1'b0, 1'b0};
    vecs[1] = '{4'b0001, 4'b0010, 1'b1, 4'b1111, 1'b0, 1'b0};
    vecs[2] = '{4'b0110, 4'b0100, 1'b0, 4'b1010, 1'b0, 1'b1};
    vecs[3] = '{4'b0110, 4'b0100, 1'b1, 4'b0010, 1'b1, 1'b0};
    vecs[4] = '{4'b1111, 4'b0010, 1'b0, 4'b0001, 1'b1, 1'b0};
    vecs[5] = '{4'b1111, 4'b0010, 1'b1, 4'b1101, 1'b1, 1'b0};
    vecs[6] = '{4'b1010, 4'b1100, 1'b0, 4'b0110, 1'b1, 1'b1};
    for (int i = 0; i < 7; i++) begin
      doOp(vecs[i].a, vecs[i].b, vecs[i].op, edges, gotDone, busyFirst);
      nCompared++;
      if (gotDone !== 1'b1 || edges != WIDTH + 1) begin
        nMismatched++;
        $display("[TB] FAIL latency_%0d: done=%b after %0d edges, required done after %0d", i, gotDone, edges, WIDTH + 1);
      end
      nCompared++;
      if (busyFirst !== 1'b1) begin
        nMismatched++;
        $display("[TB] FAIL busy_%0d: busy=%b after sampling edge, required 1", i, busyFirst);
      end
      nCompared++;
      if (S !== vecs[i].expS || Cout !== vecs[i].expC) begin
        nMismatched++;
        $display("[TB] FAIL result_%0d: S=%b Cout=%b, required S=%b Cout=%b", i, S, Cout, vecs[i].expS, vecs[i].expC);
      end
`ifdef ADDSUB_OVF_EN
      nCompared++;
      if (V !== vecs[i].expV) begin
        nMismatched++;
        $display("[TB] FAIL ovf_%0d: V=%b, required %b", i, V, vecs[i].expV);
      end
`endif
      @(posedge clk); #1;
      nCompared++;
      if (done !== 1'b0 || S !== vecs[i].expS) begin
        nMismatched++;
        $display("[TB] FAIL pulse_hold_%0d: done=%b S=%b, required done=0 S=%b", i, done, S, vecs[i].expS);
      end
    end
  endtask

  task automatic test_ignore_start();
    int doneCount, doneEdge;
    logic [WIDTH-1:0] sAtDone;
    logic cAtDone;
    A = 4'b0001; B = 4'b0010; sel = 1'b0; start = 1'b1;
    doneCount = 0; doneEdge = 0; sAtDone = '0; cAtDone = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      if (done) begin
        doneCount++;
        doneEdge = k;
        sAtDone = S;
        cAtDone = Cout;
      end
      if (k == 1) start = 1'b0;
      if (k == 2) begin
        A = 4'b1111; B = 4'b0111; sel = 1'b1; start = 1'b1;
      end
      if (k == 3) start = 1'b0;
    end
    nCompared++;
    if (doneCount != 1 || doneEdge != WIDTH + 1) begin
      nMismatched++;
      $display("[TB] FAIL ignore_start_done: %0d pulses at edge %0d, required 1 pulse at edge %0d", doneCount, doneEdge, WIDTH + 1);
    end
    nCompared++;
    if (sAtDone !== 4'b0011 || cAtDone !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL ignore_start_result: S=%b Cout=%b, required S=0011 Cout=0", sAtDone, cAtDone);
    end
    nCompared++;
    if (S !== 4'b0011 || busy !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL ignore_start_hold: S=%b busy=%b, required S=0011 busy=0", S, busy);
    end
  endtask

  task automatic test_abort();
    int doneSeen, edges;
    logic gotDone, busyFirst;
    A = 4'b0001; B = 4'b0010; sel = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    nCompared++;
    if ({busy, done, S, Cout, vObs} !== '0) begin
      nMismatched++;
      $display("[TB] FAIL abort_async: busy=%b done=%b S=%b Cout=%b V=%b, required all 0", busy, done, S, Cout, vObs);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    doneSeen = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (done || busy) doneSeen++;
    end
    nCompared++;
    if (doneSeen != 0) begin
      nMismatched++;
      $display("[TB] FAIL abort_no_done: %0d cycles with busy/done after abort, required 0", doneSeen);
    end
    doOp(4'b1010, 4'b1100, 1'b1, edges, gotDone, busyFirst);
    nCompared++;
    if (gotDone !== 1'b1 || S !== 4'b1110 || Cout !== 1'b0 || vObs !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL after_abort: done=%b S=%b Cout=%b V=%b, required done=1 S=1110 Cout=0 V=0", gotDone, S, Cout, vObs);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int edges;
    logic gotDone, busyFirst;
    doOp(4'b0001, 4'b0010, 1'b0, edges, gotDone, busyFirst);
    nCompared++;
    if (gotDone !== 1'b1 || S !== 4'b0011 || Cout !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL b2b_first: done=%b S=%b Cout=%b, required done=1 S=0011 Cout=0", gotDone, S, Cout);
    end
    // Still in DONE: new operation requested immediately.
    doOp(4'b0110, 4'b0100, 1'b0, edges, gotDone, busyFirst);
    nCompared++;
    if (busyFirst !== 1'b1) begin
      nMismatched++;
      $display("[TB] FAIL b2b_busy: busy=%b on cycle after DONE, required 1", busyFirst);
    end
    nCompared++;
    if (gotDone !== 1'b1 || edges != WIDTH + 1 || S !== 4'b1010 || Cout !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL b2b_second: done=%b edges=%0d S=%b Cout=%b, required done=1 edges=%0d S=1010 Cout=0", gotDone, edges, S, Cout, WIDTH + 1);
    end
`ifdef ADDSUB_OVF_EN
    nCompared++;
    if (V !== 1'b1) begin
      nMismatched++;
      $display("[TB] FAIL b2b_ovf: V=%b, required 1", V);
    end
`endif
  endtask

  initial begin
    nCompared = 0;
    nMismatched = 0;
    test_reset();
    test_add_sub();
    test_ignore_start();
    test_abort();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
